// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the producer handshakes and the FIFO write-side signals that the
// arbiter sits between.
//   req_valid / req_data / req_ready : per-producer valid/ready handshake,
//                                      req_data flattened, producer i at
//                                      [i*WIDTH +: WIDTH]
//   fifo_full / fifo_wr_en / fifo_data : FIFO write port
//   grant_id / busy                   : arbitration status
// Modports: master = arbiter side, slave = producers + FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_full;
   logic                  fifo_wr_en;
   logic [WIDTH-1:0]      fifo_data;
   logic [ID_W-1:0]       grant_id;
   logic                  busy;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_data, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_data, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts up to MAX_BURST accepted beats; a full FIFO stalls the
// grant without releasing it, so no word is dropped.
// Ports:
//   clk  : FIFO write clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fifo_wr_arbiter_if.master (handshakes, FIFO write port, status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; pick first valid requester at/after rr_ptr
// S_GRANT | grant_id owns the FIFO write port until burst end or drop
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   fifo_wr_arbiter_if.master bus
);
   localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_id;
   logic [CNT_W-1:0] beat_cnt;
   logic             busy;

   logic             accept;
   logic             stall_ok;
   logic [ID_W-1:0]  pick;
   logic [ID_W-1:0]  idx;
   logic             found;
   logic [ID_W-1:0]  next_ptr;
   logic [NREQ-1:0]  ready_vec;
   logic [WIDTH-1:0] data_sel;

   // Rotating priority scan starting at rr_ptr.
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ID_W'((int'(rr_ptr) + k) % NREQ);
         if (!found && bus.req_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // rst gates the handshake combinationally so the reset cycle moves no data.
   assign stall_ok = (state == S_GRANT) && !bus.fifo_full && !rst;
   assign accept   = stall_ok && bus.req_valid[grant_id];
   assign next_ptr = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;

   always_comb begin
      ready_vec = '0;
      data_sel  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (ID_W'(i) == grant_id) begin
            ready_vec[i] = stall_ok;
            data_sel     = bus.req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant_id <= pick;
                  beat_cnt <= '0;
                  state    <= S_GRANT;
                  busy     <= 1'b1;
               end
            end
            S_GRANT: begin
               // A dropped valid ends the burst even when the FIFO is full.
               if (!bus.req_valid[grant_id]) begin
                  state  <= S_IDLE;
                  busy   <= 1'b0;
                  rr_ptr <= next_ptr;
               end else if (accept) begin
                  if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                     state  <= S_IDLE;
                     busy   <= 1'b0;
                     rr_ptr <= next_ptr;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = ready_vec;
   assign bus.fifo_wr_en = accept;
   assign bus.fifo_data  = accept ? data_sel : '0;
   assign bus.grant_id   = grant_id;
   assign bus.busy       = busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
   localparam int NREQ      = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;

   logic clk;
   logic rst;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // producer model: each requester streams incrementing words
   logic [WIDTH-1:0] p_next [NREQ];
   int               p_left [NREQ];
   bit               p_en   [NREQ];
   bit               full_in;
   bit               rst_in;

   // reference model: who owns the port, beats sent, where priority starts
   int m_owner;
   int m_cnt;
   int m_ptr;
   int m_gid;

   int  wr_cnt;
   bit  prev_busy;
   int  gq[$];
   logic [WIDTH-1:0] wlog[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_cycle();
      logic [NREQ-1:0] vld;
      bit               e_wr;
      logic [NREQ-1:0]  e_rdy;
      logic [WIDTH-1:0] e_data;
      bit               found;
      int               idx;
      for (int i = 0; i < NREQ; i++) begin
         vld[i] = p_en[i] && (p_left[i] > 0);
         bus.req_data[i*WIDTH +: WIDTH] = p_next[i];
      end
      bus.req_valid = vld;
      bus.fifo_full = full_in;
      rst           = rst_in;

      e_wr   = (m_owner >= 0) && vld[m_owner] && !full_in && !rst_in;
      e_rdy  = ((m_owner >= 0) && !full_in && !rst_in) ? NREQ'(1 << m_owner) : '0;
      e_data = e_wr ? p_next[m_owner] : '0;

      @(negedge clk);
      chk("busy", bus.busy, (m_owner >= 0));
      chk("grant_id", bus.grant_id, m_gid);
      chk("req_ready", bus.req_ready, e_rdy);
      chk("fifo_wr_en", bus.fifo_wr_en, e_wr);
      chk("fifo_data", bus.fifo_data, e_data);
      if (bus.fifo_wr_en) begin
         wr_cnt++;
         wlog.push_back(bus.fifo_data);
      end
      if (bus.busy && !prev_busy) gq.push_back(int'(bus.grant_id));
      prev_busy = bus.busy;

      @(posedge clk);
      #1;
      if (rst_in) begin
         m_owner = -1; m_ptr = 0; m_gid = 0; m_cnt = 0;
      end else if (m_owner < 0) begin
         found = 0;
         for (int j = 0; j < NREQ; j++) begin
            idx = (m_ptr + j) % NREQ;
            if (!found && vld[idx]) begin
               found = 1; m_owner = idx; m_gid = idx; m_cnt = 0;
            end
         end
      end else if (!vld[m_owner]) begin
         m_ptr = (m_owner + 1) % NREQ;
         m_owner = -1;
      end else if (e_wr) begin
         p_next[m_owner] = p_next[m_owner] + 1'b1;
         p_left[m_owner]--;
         m_cnt++;
         if (m_cnt == MAX_BURST) begin
            m_ptr = (m_owner + 1) % NREQ;
            m_owner = -1;
         end
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) do_cycle();
   endtask

   task automatic clear_logs();
      wr_cnt = 0;
      gq.delete();
      wlog.delete();
   endtask

   task automatic reset_seq();
      for (int i = 0; i < NREQ; i++) p_en[i] = 0;
      full_in = 0;
      rst_in  = 1;
      run(2);
      rst_in  = 0;
      clear_logs();
   endtask

   task automatic wait_wr(input int target);
      int budget;
      budget = 50;
      while (wr_cnt < target && budget > 0) begin
         do_cycle();
         budget--;
      end
      if (wr_cnt < target) chk("wait_wr_timeout", wr_cnt, target);
   endtask

   initial begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_gid = 0;
      prev_busy = 0;
      rst_in = 1; full_in = 0;
      for (int i = 0; i < NREQ; i++) begin
         p_next[i] = '0; p_left[i] = 0; p_en[i] = 0;
      end
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      @(posedge clk); #1;

      // reset with every requester asserting
      for (int i = 0; i < NREQ; i++) begin
         p_en[i] = 1; p_left[i] = 1; p_next[i] = WIDTH'(8'hA0 + i);
      end
      rst_in = 1;
      run(2);
      rst_in = 0;
      run(1);
      chk("post_rst_busy", bus.busy, 1);
      chk("post_rst_gid", bus.grant_id, 0);
      run(12);

      // single requester, 6 words across two grants
      reset_seq();
      p_en[1] = 1; p_left[1] = 6; p_next[1] = 8'h10;
      run(12);
      chk("single_wr_cnt", wr_cnt, 6);
      for (int k = 0; k < 6; k++)
         chk("single_word", (k < wlog.size()) ? wlog[k] : 8'hxx, 8'h10 + k);
      chk("single_grants", gq.size(), 2);

      // full load
      reset_seq();
      for (int i = 0; i < NREQ; i++) begin
         p_en[i] = 1; p_left[i] = 8; p_next[i] = WIDTH'(8'h40 * i);
      end
      run(20);
      chk("full_wr_in_20", wr_cnt, 16);
      run(2);
      chk("full_ngrant", gq.size(), 5);
      for (int k = 0; k < 5; k++)
         chk("full_order", (k < gq.size()) ? gq[k] : -1, k % NREQ);

      // backpressure on requester 2
      reset_seq();
      p_en[2] = 1; p_left[2] = 4; p_next[2] = 8'h20;
      wait_wr(2);
      full_in = 1;
      run(3);
      chk("bp_hold_busy", bus.busy, 1);
      chk("bp_hold_gid", bus.grant_id, 2);
      full_in = 0;
      run(6);
      chk("bp_total", wr_cnt, 4);

      // early release by requester 2
      reset_seq();
      p_en[2] = 1; p_left[2] = 2; p_next[2] = 8'h30;
      run(1);
      p_en[0] = 1; p_left[0] = 4; p_next[0] = 8'h50;
      p_en[3] = 1; p_left[3] = 4; p_next[3] = 8'h60;
      run(16);
      chk("early_ngrant", gq.size() >= 3, 1);
      chk("early_g0", (gq.size() > 0) ? gq[0] : -1, 2);
      chk("early_g1", (gq.size() > 1) ? gq[1] : -1, 3);
      chk("early_g2", (gq.size() > 2) ? gq[2] : -1, 0);

      // reset in the middle of a burst from requester 3
      reset_seq();
      p_en[3] = 1; p_left[3] = 4; p_next[3] = 8'h70;
      wait_wr(1);
      p_en[0] = 1; p_left[0] = 4; p_next[0] = 8'h80;
      rst_in = 1;
      run(1);
      rst_in = 0;
      run(8);
      chk("rstmid_g1", (gq.size() > 1) ? gq[1] : -1, 0);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 3) == 0) p_en[i] = ~p_en[i];
            if (p_left[i] == 0 && $urandom_range(0, 4) == 0) p_left[i] = $urandom_range(1, 9);
         end
         full_in = ($urandom_range(0, 3) == 0);
         rst_in  = ($urandom_range(0, 49) == 0);
         do_cycle();
      end
      rst_in = 0; full_in = 0;
      run(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
